// File: rtl/ifetch_master.sv
// ---------------------------------------------------------------------------
// ifetch_master
//
// Instruction-fetch AXI read master. Fetches one instruction word at a time
// from the current PC and hands it to the core, then advances PC by 4. It
// supports branch/jump redirects at any point; a redirect that arrives while
// a read is in flight lets that read finish and throws the returned word away.
//
// Optional feature (macro IFETCH_RRESP_CHECK_EN):
//   defined   - a non-OKAY AXI_RRESP on a kept beat sets the sticky
//               FETCH_FAULT flag and parks the master in IDLE until reset.
//   undefined - AXI_RRESP is ignored and FETCH_FAULT stays 0.
//
// Ports:
//   AXI_ACLK, AXI_ARESET            clock, async active-high reset
//   FETCH_EN                        permits new fetches
//   REDIRECT_VALID, REDIRECT_PC     one-cycle PC redirect
//   AXI_AR*                         read-address channel (word address)
//   AXI_R*                          read-data channel
//   INSTR, INSTR_PC, INSTR_VALID,
//   INSTR_READY                     instruction stream to the core
//   FETCH_FAULT                     sticky error-response flag
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both high. A VALID, once raised, stays high with its payload unchanged
// until that transfer happens. All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ifetch_master #(
  parameter int          AXI_AWIDTH = 4,
  parameter int          AXI_DWIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESET,
  input  logic                  FETCH_EN,
  input  logic                  REDIRECT_VALID,
  input  logic [31:0]           REDIRECT_PC,
  output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
  output logic                  AXI_ARVALID,
  input  logic                  AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
  input  logic [1:0]            AXI_RRESP,
  input  logic                  AXI_RVALID,
  output logic                  AXI_RREADY,
  output logic [AXI_DWIDTH-1:0] INSTR,
  output logic [31:0]           INSTR_PC,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  output logic                  FETCH_FAULT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [AXI_AWIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [AXI_DWIDTH-1:0] instr_q, instr_d;
  logic [31:0]           instr_pc_q, instr_pc_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  discard_q, discard_d;
  logic                  fault_q, fault_d;

  logic                  ar_hs;
  logic                  r_hs;
  logic                  data_beat;
  logic                  resp_bad;
  logic [31:0]           keep_pc;
  logic [31:0]           accept_pc;

  // Byte PC to AXI word index; bits above the index and [1:0] are dropped.
  function automatic logic [AXI_AWIDTH-1:0] word_idx(input logic [31:0] p);
    return p[AXI_AWIDTH+1:2];
  endfunction

`ifdef IFETCH_RRESP_CHECK_EN
  assign resp_bad = (AXI_RRESP != 2'b00);
`else
  logic unused_rresp;
  assign unused_rresp = ^AXI_RRESP;
  assign resp_bad     = 1'b0;
`endif

  assign ar_hs = arvalid_q & AXI_ARREADY;
  assign r_hs  = rready_q & AXI_RVALID;

  // A read beat lands either together with the address (ADDR) or later (DATA).
  assign data_beat = ((state_q == S_ADDR) && ar_hs && r_hs) ||
                     ((state_q == S_DATA) && r_hs);

  // PC to refetch from after a discarded beat: a same-cycle redirect wins.
  assign keep_pc   = REDIRECT_VALID ? REDIRECT_PC : pc_q;
  // PC after the core accepts: a coincident redirect overrides PC+4.
  assign accept_pc = REDIRECT_VALID ? REDIRECT_PC : (pc_q + 32'd4);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    araddr_d      = araddr_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    discard_d     = discard_q;
    fault_d       = fault_q;

    case (state_q)
      S_IDLE: begin
        if (REDIRECT_VALID) pc_d = REDIRECT_PC;
        if (FETCH_EN && !fault_q) begin
          state_d   = S_ADDR;
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
          araddr_d  = word_idx(keep_pc);
        end
      end

      S_ADDR, S_DATA: begin
        // A redirect here cannot cancel the in-flight read; mark it so the
        // returned word is dropped. Later redirects just update the PC.
        if (REDIRECT_VALID) begin
          pc_d      = REDIRECT_PC;
          discard_d = 1'b1;
        end
        if (ar_hs) arvalid_d = 1'b0;
        if ((state_q == S_ADDR) && ar_hs && !r_hs) state_d = S_DATA;

        if (data_beat) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          if (discard_q || REDIRECT_VALID) begin
            discard_d = 1'b0;
            if (FETCH_EN) begin
              state_d   = S_ADDR;
              arvalid_d = 1'b1;
              rready_d  = 1'b1;
              araddr_d  = word_idx(keep_pc);
            end else begin
              state_d = S_IDLE;
            end
          end else if (resp_bad) begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            instr_d       = AXI_RDATA;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (INSTR_READY) begin
          instr_valid_d = 1'b0;
          pc_d          = accept_pc;
          if (FETCH_EN) begin
            state_d   = S_ADDR;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            araddr_d  = word_idx(accept_pc);
          end else begin
            state_d = S_IDLE;
          end
        end else if (REDIRECT_VALID) begin
          // Withdraw the stale instruction and refetch from the target.
          pc_d          = REDIRECT_PC;
          instr_valid_d = 1'b0;
          state_d       = S_ADDR;
          arvalid_d     = 1'b1;
          rready_d      = 1'b1;
          araddr_d      = word_idx(REDIRECT_PC);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      discard_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      araddr_q      <= araddr_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      discard_q     <= discard_d;
      fault_q       <= fault_d;
    end
  end

  assign AXI_ARADDR  = araddr_q;
  assign AXI_ARVALID = arvalid_q;
  assign AXI_RREADY  = rready_q;
  assign INSTR       = instr_q;
  assign INSTR_PC    = instr_pc_q;
  assign INSTR_VALID = instr_valid_q;
  assign FETCH_FAULT = fault_q;

endmodule

// File: tb/tb_ifetch_master.sv
// ---------------------------------------------------------------------------
// tb_ifetch_master
//
// Directed bench for ifetch_master. A small AXI read responder answers with
// RDATA = 32'h13 | (word_address << 20) after programmable delays; a monitor
// logs AR handshakes and accepted instructions. Each test task drives one
// scenario and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ifetch_master;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          fetch_en;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] instr;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          fetch_fault;

  int checks = 0;
  int errors = 0;

  // responder controls (written only by the initial block)
  int       ar_delay = 0;
  int       r_delay  = 0;
  logic [1:0] resp_val = 2'b00;

  // responder / monitor state (written only by the monitor)
  logic          pending;
  logic [AW-1:0] pend_addr;
  int            r_cnt;
  int            ar_cnt;
  int            ar_count;
  int            arv_cycles;
  int            unstable;
  logic          arv_seen;
  logic [AW-1:0] arv_prev;
  logic          hs_ar;
  logic          hs_r;
  logic [AW-1:0] ar_log[$];
  logic [63:0]   got_q[$];

  logic [63:0]   exp_q[$];

  ifetch_master #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .RESET_PC(32'h0)) dut (
    .AXI_ACLK       (clk),
    .AXI_ARESET     (rst),
    .FETCH_EN       (fetch_en),
    .REDIRECT_VALID (redirect_valid),
    .REDIRECT_PC    (redirect_pc),
    .AXI_ARADDR     (araddr),
    .AXI_ARVALID    (arvalid),
    .AXI_ARREADY    (arready),
    .AXI_RDATA      (rdata),
    .AXI_RRESP      (rresp),
    .AXI_RVALID     (rvalid),
    .AXI_RREADY     (rready),
    .INSTR          (instr),
    .INSTR_PC       (instr_pc),
    .INSTR_VALID    (instr_valid),
    .INSTR_READY    (instr_ready),
    .FETCH_FAULT    (fetch_fault)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {28'd0, a};
    return 32'h0000_0013 | (w << 20);
  endfunction

  // ---------------- responder (drives on negedge) ----------------
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = '0;
      rresp   = 2'b00;
    end else begin
      arready = arvalid && (ar_cnt >= ar_delay);
      rvalid  = (arvalid && arready && (r_delay == 0)) ||
                (pending && (r_cnt >= r_delay));
      rdata   = mem_word(pending ? pend_addr : araddr);
      rresp   = resp_val;
    end
  end

  // ---------------- monitor (samples pre-edge values) ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    = 1'b0;
      pend_addr  = '0;
      r_cnt      = 0;
      ar_cnt     = 0;
      ar_count   = 0;
      arv_cycles = 0;
      unstable   = 0;
      arv_seen   = 1'b0;
      arv_prev   = '0;
      ar_log.delete();
      got_q.delete();
    end else begin
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      if (arvalid) begin
        arv_cycles++;
        if (arv_seen && (araddr != arv_prev)) unstable++;
        arv_seen = 1'b1;
        arv_prev = araddr;
      end else begin
        arv_seen = 1'b0;
      end
      if (hs_ar) begin
        ar_count++;
        ar_log.push_back(araddr);
        ar_cnt = 0;
        arv_seen = 1'b0;
      end else if (arvalid) begin
        ar_cnt++;
      end
      if (hs_r) pending = 1'b0;
      else if (hs_ar) begin
        pending   = 1'b1;
        pend_addr = araddr;
        r_cnt     = 0;
      end else if (pending) r_cnt++;
      if (instr_valid && instr_ready) got_q.push_back({instr_pc, instr});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic fe);
    @(negedge clk);
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    ar_delay       = 0;
    r_delay        = 0;
    resp_val       = 2'b00;
    exp_q.delete();
    repeat (2) @(negedge clk);
    fetch_en = fe;
    rst      = 1'b0;
  endtask

  task automatic wait_got(input int n, input string name);
    int budget;
    budget = 200;
    while ((got_q.size() < n) && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    if (got_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d instrs want %0d", name, got_q.size(), n);
    end
  endtask

  task automatic wait_instr_valid(input string name);
    int budget;
    budget = 200;
    while (!instr_valid && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting INSTR_VALID", name);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Put the DUT in HOLD with non-zero state, then hit reset between edges.
    do_reset(1'b1);
    wait_instr_valid("reset_prep");
    #2;
    rst = 1'b1;
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", rready); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    checks++; if (araddr !== 4'h0) begin errors++; $display("FAIL reset_araddr: got %h want 0", araddr); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
    // Release with FETCH_EN high: no AR handshake at the first edge.
    do_reset(1'b1);
    @(negedge clk);
    checks++; if (ar_count !== 0) begin errors++; $display("FAIL reset_first_ar: got %0d handshakes want 0", ar_count); end
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL reset_arvalid_rise: got %b want 1", arvalid); end
  endtask

  task automatic test_basic();
    do_reset(1'b1);
    instr_ready = 1'b1;
    wait_got(2, "basic");
    fetch_en = 1'b0;
    repeat (6) @(negedge clk);
    if (got_q.size() >= 2 && ar_log.size() >= 2) begin
      checks++; if (ar_log[0] !== 4'd0) begin errors++; $display("FAIL basic_araddr0: got %0d want 0", ar_log[0]); end
      checks++; if (got_q[0] !== {32'h0, 32'h0000_0013}) begin errors++; $display("FAIL basic_instr0: got %h want %h", got_q[0], {32'h0, 32'h0000_0013}); end
      checks++; if (ar_log[1] !== 4'd1) begin errors++; $display("FAIL basic_araddr1: got %0d want 1", ar_log[1]); end
      checks++; if (got_q[1] !== {32'h4, 32'h0010_0013}) begin errors++; $display("FAIL basic_instr1: got %h want %h", got_q[1], {32'h4, 32'h0010_0013}); end
    end
  endtask

  task automatic test_delay();
    do_reset(1'b1);
    ar_delay    = 3;
    r_delay     = 2;
    instr_ready = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;   // allow only the fetch already started
    repeat (20) @(negedge clk);
    checks++; if (arv_cycles !== 4) begin errors++; $display("FAIL delay_arvalid_cycles: got %0d want 4", arv_cycles); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL delay_araddr_stable: got %0d changes want 0", unstable); end
    checks++; if (ar_count !== 1) begin errors++; $display("FAIL delay_ar_count: got %0d want 1", ar_count); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL delay_instr_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== {32'h0, 32'h0000_0013}) begin errors++; $display("FAIL delay_instr: got %h want %h", got_q[0], {32'h0, 32'h0000_0013}); end
    end
  endtask

  task automatic test_hold();
    do_reset(1'b1);
    wait_instr_valid("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ((instr !== 32'h13) || (instr_pc !== 32'h0) || (instr_valid !== 1'b1)) begin
        errors++;
        $display("FAIL hold_stable%0d: got v=%b pc=%h i=%h want v=1 pc=0 i=13", i, instr_valid, instr_pc, instr);
      end
    end
    checks++; if (ar_count !== 1) begin errors++; $display("FAIL hold_no_new_ar: got %0d want 1", ar_count); end
    instr_ready = 1'b1;
    fetch_en    = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL hold_accept_count: got %0d want 1", got_q.size()); end
    checks++; if (ar_count !== 1) begin errors++; $display("FAIL hold_ar_after_accept: got %0d want 1", ar_count); end
  endtask

  task automatic test_redirect_data();
    int budget;
    do_reset(1'b1);
    r_delay     = 3;
    instr_ready = 1'b1;
    budget = 50;
    while ((ar_count < 1) && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_got(1, "redirect_data");
    fetch_en = 1'b0;
    repeat (12) @(negedge clk);
    if (got_q.size() >= 1 && ar_log.size() >= 2) begin
      checks++; if (got_q[0] !== {32'h20, 32'h0080_0013}) begin errors++; $display("FAIL redir_data_instr: got %h want %h", got_q[0], {32'h20, 32'h0080_0013}); end
      checks++; if (ar_log[1] !== 4'd8) begin errors++; $display("FAIL redir_data_araddr: got %0d want 8", ar_log[1]); end
    end else begin
      checks++; errors++;
      $display("FAIL redir_data_progress: got %0d instrs %0d ARs want >=1 >=2", got_q.size(), ar_log.size());
    end
  endtask

  task automatic test_redirect_accept();
    logic [63:0] e;
    do_reset(1'b1);
    wait_instr_valid("redir_accept");
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_q.push_back({32'h00, 32'h0000_0013});
    exp_q.push_back({32'h10, 32'h0040_0013});
    exp_q.push_back({32'h14, 32'h0050_0013});
    wait_got(3, "redir_accept");
    fetch_en = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      if (got_q.size() > i) begin
        checks++;
        if (got_q[i] !== e) begin errors++; $display("FAIL redir_accept_instr%0d: got %h want %h", i, got_q[i], e); end
      end
    end
    if (ar_log.size() >= 2) begin
      checks++; if (ar_log[1] !== 4'd4) begin errors++; $display("FAIL redir_accept_araddr: got %0d want 4", ar_log[1]); end
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    instr_ready    = 1'b1;
    fetch_en       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_got(2, "wrap");
    fetch_en = 1'b0;
    repeat (6) @(negedge clk);
    if (got_q.size() >= 2 && ar_log.size() >= 2) begin
      checks++; if (ar_log[0] !== 4'd15) begin errors++; $display("FAIL wrap_araddr0: got %0d want 15", ar_log[0]); end
      checks++; if (got_q[0] !== {32'hFFFF_FFFC, 32'h00F0_0013}) begin errors++; $display("FAIL wrap_instr0: got %h want %h", got_q[0], {32'hFFFF_FFFC, 32'h00F0_0013}); end
      checks++; if (ar_log[1] !== 4'd0) begin errors++; $display("FAIL wrap_araddr1: got %0d want 0", ar_log[1]); end
      checks++; if (got_q[1] !== {32'h0, 32'h0000_0013}) begin errors++; $display("FAIL wrap_instr1: got %h want %h", got_q[1], {32'h0, 32'h0000_0013}); end
    end
  endtask

`ifdef IFETCH_RRESP_CHECK_EN
  task automatic test_fault();
    do_reset(1'b1);
    resp_val    = 2'b10;
    instr_ready = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_flag: got %b want 1", fetch_fault); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL fault_no_instr: got %0d want 0", got_q.size()); end
    checks++; if (ar_count !== 1) begin errors++; $display("FAIL fault_no_more_ar: got %0d want 1", ar_count); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fault_instr_valid: got %b want 0", instr_valid); end
    do_reset(1'b0);
    @(negedge clk);
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_cleared: got %b want 0", fetch_fault); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    test_reset();
    test_basic();
    test_delay();
    test_hold();
    test_redirect_data();
    test_redirect_accept();
    test_wrap();
`ifdef IFETCH_RRESP_CHECK_EN
    test_fault();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_master.md
IFETCH_MASTER -- requirements
Module: ifetch_master

Interface
REQ-001 SHALL have parameter AXI_AWIDTH, default 4, word-address width of AXI_ARADDR.
REQ-002 SHALL have parameter AXI_DWIDTH, default 32, instruction/data width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, byte PC loaded at reset.
REQ-004 SHALL have port AXI_ACLK  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port AXI_ARESET  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port FETCH_EN  in  1  high permits new fetches.
REQ-007 SHALL have port REDIRECT_VALID  in  1  one-cycle PC redirect (branch/jump).
REQ-008 SHALL have port REDIRECT_PC  in  32  redirect target byte address.
REQ-009 SHALL have ports AXI_ARADDR out AXI_AWIDTH, AXI_ARVALID out 1, AXI_ARREADY in 1: read-address channel.
REQ-010 SHALL have ports AXI_RDATA in AXI_DWIDTH, AXI_RRESP in 2, AXI_RVALID in 1, AXI_RREADY out 1: read-data channel.
REQ-011 SHALL have ports INSTR out AXI_DWIDTH, INSTR_PC out 32, INSTR_VALID out 1, INSTR_READY in 1: instruction to core.
REQ-012 SHALL have port FETCH_FAULT  out  1  sticky error-response flag.

Function
REQ-013 SHALL be a four-state FSM: IDLE, ADDR, DATA, HOLD; all outputs registered.
REQ-014 AXI_ARADDR SHALL equal PC[AXI_AWIDTH+1:2] (word index); PC bits above and [1:0] ignored.
REQ-015 IDLE: FETCH_EN=1 -> ADDR next cycle; else stay.
REQ-016 ADDR: AXI_ARVALID=1 and AXI_RREADY=1 together (responders may require both before answering).
REQ-017 ADDR: AXI_ARADDR and AXI_ARVALID SHALL stay stable until AXI_ARVALID&AXI_ARREADY.
REQ-018 ADDR: AR handshake with simultaneous R handshake -> capture data, go HOLD; AR handshake alone -> DATA (ARVALID=0, RREADY=1).
REQ-019 DATA: on AXI_RVALID&AXI_RREADY capture AXI_RDATA into INSTR, PC into INSTR_PC, go HOLD.
REQ-020 HOLD: INSTR_VALID=1, RREADY=0; INSTR/INSTR_PC stable until INSTR_READY.
REQ-021 HOLD accept (INSTR_READY=1): PC<=PC+4 (32-bit wrap), -> ADDR if FETCH_EN else IDLE; minimum throughput one instruction per 3 cycles.
REQ-022 Redirect in IDLE or HOLD: PC<=REDIRECT_PC; HOLD drops INSTR_VALID next cycle and goes ADDR (IDLE obeys REQ-015).
REQ-023 Redirect in ADDR or DATA: PC<=REDIRECT_PC, set discard flag; outstanding transaction completes per REQ-017; returned data SHALL NOT reach HOLD; flag cleared, -> ADDR with new PC.
REQ-024 Redirect coincident with HOLD accept: handshake completes, next fetch from REDIRECT_PC (redirect overrides PC+4).
REQ-025 Second redirect while discard flag set: latest REDIRECT_PC wins; exactly one response discarded.
REQ-026 FETCH_EN deassert mid-transaction: outstanding transaction completes; no new AR issued.

Reset
REQ-027 AXI_ARESET SHALL asynchronously force: state IDLE, PC=RESET_PC, AXI_ARVALID=0, AXI_RREADY=0, INSTR_VALID=0, INSTR=0, INSTR_PC=0, AXI_ARADDR=0, FETCH_FAULT=0, discard flag 0.
REQ-028 Reset mid-transaction SHALL abandon it; responder re-synchronisation is the system's responsibility.
REQ-029 First AR after reset release SHALL appear no earlier than second rising edge with FETCH_EN=1.

Configuration
REQ-030 Macro IFETCH_RRESP_CHECK_EN defined: captured AXI_RRESP!=2'b00 on a non-discarded beat sets FETCH_FAULT (sticky until reset), suppresses INSTR_VALID, FSM parks in IDLE ignoring FETCH_EN; redirect does not clear it.
REQ-031 Macro undefined: AXI_RRESP ignored, FETCH_FAULT tied 0.

Verification
REQ-032 Reset, FETCH_EN=1, responder ARREADY=RVALID=1 same cycle as ARVALID&RREADY, RDATA=32'h00000013 -> ARADDR=0, INSTR=32'h00000013, INSTR_PC=0; next ARADDR=1.
REQ-033 ARREADY delayed 3 cycles, RVALID 2 cycles later -> ARADDR/ARVALID stable 4 cycles, single INSTR_VALID with correct data.
REQ-034 INSTR_READY held low 5 cycles in HOLD -> INSTR/INSTR_PC unchanged, no new AR until accept.
REQ-035 REDIRECT_VALID, REDIRECT_PC=32'h20 during DATA -> returned word discarded (no INSTR_VALID), next ARADDR=8, INSTR_PC=32'h20.
REQ-036 PC=32'hFFFF_FFFC accepted -> next PC 0, ARADDR=0.
REQ-037 With IFETCH_RRESP_CHECK_EN, RRESP=2'b10 -> FETCH_FAULT=1, no INSTR_VALID, no further AR; AXI_ARESET clears.
